bitmask_walker: RTL and testbench
=================================

// Module: bitmask_walker
// PURPOSE
//  Sequencer for the 32-bit leading-zero counter: accepts a 32-bit occupancy/sparsity mask
//  and emits the position of every set bit, MSB first, one per accepted handshake.
//  Used by buffet fill/drain control to walk sparse bitmaps.
//  Each step feeds the working mask through one leadingZero32 instance.
//  It then clears the emitted bit and repeats until the mask is empty.
// PARAMETERS
//  WIDTH    32  mask width; only 32 is supported (bound to leadingZero32)
//  IDX_W    5   index width, log2(WIDTH)
//  CNT_W    6   done_count width, log2(WIDTH)+1
// PORTS
//  clk         in   1      clock, all state on rising edge
//  nreset      in   1      asynchronous active-low reset
//  flush       in   1      synchronous abort of current mask
//  mask_valid  in   1      mask_data valid
//  mask_ready  out  1      walker can accept a mask
//  mask_data   in   32     mask to walk
//  idx_valid   out  1      idx_data valid
//  idx_ready   in   1      consumer accepts idx_data
//  idx_data    out  5      bit position of current highest set bit, = 31 - lz(work)
//  idx_last    out  1      idx_data is the final set bit of this mask
//  done        out  1      one-cycle pulse: mask fully walked
//  done_count  out  6      number of indices emitted for the finished mask (valid with done)
// BEHAVIOUR
//  - Reset (nreset=0, async): state=IDLE, work=0, count=0.
//    mask_ready=0 during reset and 1 after it; idx_valid=0, idx_last=0, done=0, done_count=0.
//  - FSM states: IDLE, WALK, DONE.
//  - IDLE: mask_ready=1, idx_valid=0.
//    On mask_valid&mask_ready: work<=mask_data, count<=0.
//    Next state is WALK if mask_data!=0, else DONE.
//  - WALK: mask_ready=0, idx_valid=1.
//    idx_data and idx_last are derived combinationally from the registered work.
//    idx_last = ((work & ~(1<<idx_data)) == 0).
//    On idx_valid&idx_ready: clear bit idx_data in work, count<=count+1.
//    Next state is DONE if idx_last, else stay in WALK.
//    Without idx_ready, idx_valid/idx_data/idx_last hold stable; no retraction.
//  - DONE: single cycle, done=1, done_count=count; next state IDLE. mask_ready=0 in DONE.
//  - Latency: mask accepted at cycle T -> first idx_valid at T+1.
//    All-zero mask accepted at T -> done at T+1 with done_count=0; no idx_valid ever.
//  - Throughput: 1 index/cycle with idx_ready held high; the gap between masks is 2 cycles (DONE, IDLE).
//  - count width 6: a full mask yields done_count=32; count never wraps.
//  - flush=1 (any state): next state IDLE, work<=0, count<=0, no done pulse.
//    flush has priority over a same-cycle idx or mask handshake.
//    A handshake in that cycle still completes on the wire but is discarded.
//  - leadingZero32 value 32 (work==0) is never used to drive idx_data while idx_valid=1.
//  - done and idx_valid are never high in the same cycle.
//  - nreset assertion mid-walk: outputs go to reset values immediately; the partial mask is lost.
// TESTING
//  1. mask 0x8000_0001, idx_ready=1 -> idx 31 (last=0), 0 (last=1) on consecutive cycles;
//     then done=1, done_count=2.
//  2. mask 0x0000_0000 accepted at T -> idx_valid never high; done=1 at T+1, done_count=0;
//     mask_ready=1 at T+2.
//  3. mask 0x0000_00F0, idx_ready toggling 1,0,0,1,... -> idx 7,6,5,4 each held stable while stalled;
//     last only on 4; done_count=4.
//  4. mask 0xFFFF_FFFF, idx_ready=1 -> 32 back-to-back indices 31..0; done_count=32 (6'b100000).
//  5. mask 0x0101_0101, flush asserted after 2 indices accepted -> idx_valid=0 next cycle;
//     no done pulse; mask_ready=1; next mask walks cleanly from count=0.
//  6. nreset pulsed low mid-walk (async, between edges) -> idx_valid/done drop immediately;
//     after release mask_ready=1, work empty.

Source files
------------

// File: rtl/bitmask_walker.sv
// bitmask_walker: walks a 32-bit mask and emits each set-bit position MSB first, one per handshake
module leadingZero32 (
  input  logic [31:0] in_data,
  output logic [5:0]  lz
);
  always_comb begin
    lz = 6'd32;
    for (int i = 0; i < 32; i++) if (in_data[i]) lz = 6'(31 - i);
  end
endmodule

module bitmask_walker #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             flush,
  input  logic             mask_valid,
  output logic             mask_ready,
  input  logic [WIDTH-1:0] mask_data,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [IDX_W-1:0] idx_data,
  output logic             idx_last,
  output logic             done,
  output logic [CNT_W-1:0] done_count
);
  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d, rest;
  logic [CNT_W-1:0] count_q, count_d;
  logic [5:0]       lz;
  leadingZero32 u_lz (.in_data(work_q), .lz(lz));
  always_comb begin
    idx_valid  = state_q == WALK;
    idx_data   = idx_valid ? ~lz[IDX_W-1:0] : '0;
    rest       = work_q & ~(WIDTH'(1) << idx_data);
    idx_last   = idx_valid && rest == '0;
    mask_ready = nreset && state_q == IDLE;
    done       = state_q == DONE;
    done_count = done ? count_q : '0;
    state_d    = state_q;
    work_d     = work_q;
    count_d    = count_q;
    if (flush) begin
      state_d = IDLE;
      work_d  = '0;
      count_d = '0;
    end else if (mask_ready && mask_valid) begin
      work_d  = mask_data;
      count_d = '0;
      state_d = mask_data != '0 ? WALK : DONE;
    end else if (idx_valid && idx_ready) begin
      work_d  = rest;
      count_d = count_q + CNT_W'(1);
      state_d = idx_last ? DONE : WALK;
    end else if (done) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      work_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_bitmask_walker.sv
// tb_bitmask_walker: directed and random checks of bitmask_walker against a queue-based model
module tb_bitmask_walker;
  logic        clk = 0, nreset = 0, flush = 0, mask_valid = 0, idx_ready = 0;
  logic [31:0] mask_data = '0;
  logic        mask_ready, idx_valid, idx_last, done;
  logic [4:0]  idx_data;
  logic [5:0]  done_count;
  int total = 0, bad = 0;
  logic [4:0] mq[$];
  logic       m_done;
  int         m_n;
  int         lg[$];
  int         lastn, dcnt, dseen;

  bitmask_walker dut (
    .clk(clk), .nreset(nreset), .flush(flush), .mask_valid(mask_valid), .mask_ready(mask_ready),
    .mask_data(mask_data), .idx_valid(idx_valid), .idx_ready(idx_ready), .idx_data(idx_data),
    .idx_last(idx_last), .done(done), .done_count(done_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pending indices of the current mask, plus a pending done pulse
  always @(posedge clk or negedge nreset) begin
    if (!nreset || flush) begin
      mq.delete();
      m_done <= 0;
      m_n    <= 0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (mq.size() != 0) begin
      if (idx_ready) begin
        void'(mq.pop_front());
        m_n <= m_n + 1;
        if (mq.size() == 0) m_done <= 1;
      end
    end else if (mask_valid) begin
      m_n <= 0;
      for (int i = 31; i >= 0; i--) if (mask_data[i]) mq.push_back(5'(i));
      if (mask_data == 0) m_done <= 1;
    end
  end

  always @(negedge clk) begin
    chk("idx_valid", idx_valid, mq.size() != 0);
    chk("done", done, m_done);
    chk("done_count", done_count, m_done ? m_n : 0);
    chk("mask_ready", mask_ready, nreset && mq.size() == 0 && !m_done);
    if (mq.size() != 0) begin
      chk("idx_data", idx_data, mq[0]);
      chk("idx_last", idx_last, mq.size() == 1);
    end
    if (nreset && !flush && idx_valid && idx_ready) begin
      lg.push_back(int'(idx_data));
      if (idx_last) lastn++;
    end
    if (nreset && done) begin
      dcnt = done_count;
      dseen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clr_log();
    lg.delete();
    lastn = 0;
    dcnt  = -1;
  endtask

  task automatic send(input logic [31:0] m);
    int k = 0;
    mask_valid = 1;
    mask_data  = m;
    while (!mask_ready && k < 200) begin
      tick(1);
      k++;
    end
    chk("send_timeout", int'(mask_ready), 1);
    tick(1);
    mask_valid = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!mask_ready && k < 200) begin
      tick(1);
      k++;
    end
    chk("idle_timeout", int'(mask_ready), 1);
  endtask

  initial begin
    logic [3:0] pat;
    int k, ds;
    #1 chk("rst_mask_ready", mask_ready, 0);
    chk("rst_idx_valid", idx_valid, 0);
    chk("rst_done_count", done_count, 0);
    tick(2);
    nreset = 1;
    tick(1);
    chk("post_rst_ready", mask_ready, 1);

    clr_log();
    idx_ready = 1;
    send(32'h8000_0001);
    wait_idle();
    chk("t1_n", lg.size(), 2);
    chk("t1_i0", lg[0], 31);
    chk("t1_i1", lg[1], 0);
    chk("t1_last", lastn, 1);
    chk("t1_dc", dcnt, 2);

    clr_log();
    send(32'h0);
    chk("t2_done", done, 1);
    chk("t2_dc", done_count, 0);
    chk("t2_valid", idx_valid, 0);
    tick(1);
    chk("t2_ready", mask_ready, 1);
    chk("t2_n", lg.size(), 0);

    clr_log();
    pat = 4'b1001;
    send(32'h0000_00F0);
    k = 0;
    while (!mask_ready && k < 200) begin
      idx_ready = pat[k % 4];
      tick(1);
      k++;
    end
    chk("t3_n", lg.size(), 4);
    chk("t3_i0", lg[0], 7);
    chk("t3_i3", lg[3], 4);
    chk("t3_last", lastn, 1);
    chk("t3_dc", dcnt, 4);

    clr_log();
    idx_ready = 1;
    send(32'hFFFF_FFFF);
    tick(31);
    chk("t4_b2b", lg.size(), 31);
    wait_idle();
    chk("t4_n", lg.size(), 32);
    chk("t4_i0", lg[0], 31);
    chk("t4_i31", lg[31], 0);
    chk("t4_dc", dcnt, 32);

    clr_log();
    ds = dseen;
    send(32'h0101_0101);
    tick(2);
    flush = 1;
    tick(1);
    flush = 0;
    chk("t5_valid", idx_valid, 0);
    chk("t5_ready", mask_ready, 1);
    chk("t5_n", lg.size(), 2);
    tick(2);
    chk("t5_nodone", dseen, ds);
    clr_log();
    send(32'h0000_0003);
    wait_idle();
    chk("t5_i0", lg[0], 1);
    chk("t5_dc", dcnt, 2);

    clr_log();
    send(32'hFFFF_0000);
    tick(3);
    #1 nreset = 0;
    #1 chk("t6_valid", idx_valid, 0);
    chk("t6_done", done, 0);
    chk("t6_ready", mask_ready, 0);
    tick(2);
    nreset = 1;
    tick(1);
    chk("t6_ready_rel", mask_ready, 1);
    clr_log();
    send(32'h0000_0010);
    wait_idle();
    chk("t6_n", lg.size(), 1);
    chk("t6_i0", lg[0], 4);
    chk("t6_dc", dcnt, 1);

    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0: mask_data = $urandom & $urandom & $urandom;
        1: mask_data = $urandom;
        2: mask_data = ($urandom % 3 == 0) ? 32'h0 : 32'hFFFF_FFFF;
        default: mask_data = 32'h1 << $urandom_range(0, 31);
      endcase
      mask_valid = $urandom_range(0, 1) == 1;
      idx_ready  = $urandom_range(0, 3) != 0;
      flush      = $urandom_range(0, 39) == 0;
      tick(1);
    end
    flush = 0;
    mask_valid = 0;
    idx_ready = 1;
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
